// File: rtl/adder_operand_serializer.sv
// Splits a pair of wide operand blocks into per-lane beats (LSB lane first)
// for the narrow adder, with valid/ready handshakes on both sides.
module adder_operand_serializer #(
  parameter int DATA_W    = 8,
  parameter int NUM_LANES = 16,
  parameter int IDX_W     = $clog2(NUM_LANES)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        blk_valid_in,
  output logic                        blk_ready_out,
  input  logic [DATA_W*NUM_LANES-1:0] blk_a_in,
  input  logic [DATA_W*NUM_LANES-1:0] blk_b_in,
  output logic [DATA_W-1:0]           adder_a_out,
  output logic [DATA_W-1:0]           adder_b_out,
  output logic                        lane_valid_out,
  input  logic                        lane_ready_in,
  output logic [IDX_W-1:0]            lane_idx_out,
  output logic                        lane_last_out,
  output logic                        dbg_state_out
);

  localparam int BLK_W = DATA_W * NUM_LANES;
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_LANES - 1);
  localparam logic [IDX_W-1:0] PRE_LAST_IDX = IDX_W'(NUM_LANES - 2);

  typedef enum logic {ST_IDLE, ST_SEND} state_e;

  // Handshake rule on both ports: a transfer happens on a rising edge where
  // valid && ready; valid never depends on ready, and ready may depend on valid.
  state_e             state_q;
  logic [IDX_W-1:0]   cnt_q;
  logic [BLK_W-1:0]   sh_a_q;
  logic [BLK_W-1:0]   sh_b_q;
  logic               valid_q;
  logic               last_q;
  logic               lane_hs;
  logic               blk_hs;

  assign lane_hs       = valid_q && lane_ready_in;
  assign blk_ready_out = !rst && ((state_q == ST_IDLE) ||
                                  ((state_q == ST_SEND) && last_q && lane_ready_in));
  assign blk_hs        = blk_valid_in && blk_ready_out;

  assign adder_a_out    = sh_a_q[DATA_W-1:0];
  assign adder_b_out    = sh_b_q[DATA_W-1:0];
  assign lane_valid_out = valid_q;
  assign lane_idx_out   = cnt_q;
  assign lane_last_out  = last_q;
  assign dbg_state_out  = (state_q == ST_SEND);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (blk_hs) begin
            sh_a_q  <= blk_a_in;
            sh_b_q  <= blk_b_in;
            cnt_q   <= '0;
            valid_q <= 1'b1;
            last_q  <= 1'b0;
            state_q <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (lane_hs) begin
            if (last_q) begin
              cnt_q  <= '0;
              last_q <= 1'b0;
              // A waiting block is taken on the last-lane beat so lanes stay gapless.
              if (blk_hs) begin
                sh_a_q <= blk_a_in;
                sh_b_q <= blk_b_in;
              end else begin
                sh_a_q  <= '0;
                sh_b_q  <= '0;
                valid_q <= 1'b0;
                state_q <= ST_IDLE;
              end
            end else begin
              sh_a_q <= {{DATA_W{1'b0}}, sh_a_q[BLK_W-1:DATA_W]};
              sh_b_q <= {{DATA_W{1'b0}}, sh_b_q[BLK_W-1:DATA_W]};
              cnt_q  <= cnt_q + IDX_W'(1);
              last_q <= (cnt_q == PRE_LAST_IDX);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // LAST_IDX documents the counter's terminal value; last_q tracks it one beat ahead.
  logic unused_last_idx;
  assign unused_last_idx = ^LAST_IDX;

endmodule

// File: tb/tb_adder_operand_serializer.sv
// Directed bench for adder_operand_serializer: reset, single block, back-to-back,
// backpressure, input change after accept and reset in the middle of a block.
module tb_adder_operand_serializer;

  localparam int DW     = 8;
  localparam int NL     = 16;
  localparam int IW     = 4;
  localparam int BW     = DW * NL;
  localparam int LREC_W = 2 * DW + IW + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          blk_valid_in;
  logic          blk_ready_out;
  logic [BW-1:0] blk_a_in;
  logic [BW-1:0] blk_b_in;
  logic [DW-1:0] adder_a_out;
  logic [DW-1:0] adder_b_out;
  logic          lane_valid_out;
  logic          lane_ready_in;
  logic [IW-1:0] lane_idx_out;
  logic          lane_last_out;
  logic          dbg_state_out;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0]     la[NL];
  logic [DW-1:0]     lb[NL];
  logic [LREC_W-1:0] exp_q[$];
  logic [LREC_W-1:0] exp_v;
  logic [LREC_W-1:0] obs;

  assign obs = {adder_a_out, adder_b_out, lane_idx_out, lane_last_out};

  adder_operand_serializer #(.DATA_W(DW), .NUM_LANES(NL), .IDX_W(IW)) dut (
    .clk            (clk),
    .rst            (rst),
    .blk_valid_in   (blk_valid_in),
    .blk_ready_out  (blk_ready_out),
    .blk_a_in       (blk_a_in),
    .blk_b_in       (blk_b_in),
    .adder_a_out    (adder_a_out),
    .adder_b_out    (adder_b_out),
    .lane_valid_out (lane_valid_out),
    .lane_ready_in  (lane_ready_in),
    .lane_idx_out   (lane_idx_out),
    .lane_last_out  (lane_last_out),
    .dbg_state_out  (dbg_state_out)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: bench still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  // drivers
  task automatic drive_block();
    for (int i = 0; i < NL; i++) begin
      blk_a_in[i*DW +: DW] = la[i];
      blk_b_in[i*DW +: DW] = lb[i];
    end
  endtask

  task automatic push_block();
    for (int i = 0; i < NL; i++)
      exp_q.push_back({la[i], lb[i], IW'(i), (i == NL - 1)});
  endtask

  // Offers the current la/lb block while idle and returns #1 after the accepting edge.
  task automatic send_block();
    drive_block();
    push_block();
    blk_valid_in = 1'b1;
    @(posedge clk); #1;
    blk_valid_in = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; blk_valid_in = 1'b0; lane_ready_in = 1'b0;
    blk_a_in = '0; blk_b_in = '0;
    @(posedge clk); @(posedge clk); #1;
    total++;
    if (obs !== '0 || lane_valid_out !== 1'b0 || blk_ready_out !== 1'b0 || dbg_state_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got rec=%h v=%0b rdy=%0b st=%0b, want all 0", obs, lane_valid_out, blk_ready_out, dbg_state_out);
    end
    rst = 1'b0; #1;
    total++;
    if (blk_ready_out !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: got %0b want 1", blk_ready_out);
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      total++;
      if (lane_valid_out !== 1'b0 || blk_ready_out !== 1'b1 || obs !== '0) begin
        bad++;
        $display("FAIL idle_cycle%0d: got v=%0b rdy=%0b rec=%h want v=0 rdy=1 rec=0", c, lane_valid_out, blk_ready_out, obs);
      end
    end
  endtask

  task automatic test_single();
    for (int i = 0; i < NL; i++) begin la[i] = 8'(i); lb[i] = 8'(8'hF0 + i); end
    lane_ready_in = 1'b1;
    send_block();
    for (int i = 0; i < NL; i++) begin
      exp_v = exp_q.pop_front();
      total++;
      if (lane_valid_out !== 1'b1 || obs !== exp_v) begin
        bad++;
        $display("FAIL single_lane%0d: got v=%0b rec=%h want v=1 rec=%h", i, lane_valid_out, obs, exp_v);
      end
      @(posedge clk); #1;
    end
    total++;
    if (lane_valid_out !== 1'b0 || blk_ready_out !== 1'b1) begin
      bad++;
      $display("FAIL single_end: got v=%0b rdy=%0b want v=0 rdy=1", lane_valid_out, blk_ready_out);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < NL; i++) begin la[i] = 8'(i); lb[i] = 8'(8'hF0 + i); end
    lane_ready_in = 1'b1;
    drive_block();
    push_block();
    blk_valid_in = 1'b1;
    @(posedge clk); #1;
    // Second block is offered continuously while the first one drains.
    for (int i = 0; i < NL; i++) begin la[i] = 8'hAA; lb[i] = 8'h55; end
    drive_block();
    push_block();
    for (int i = 0; i < 2 * NL; i++) begin
      if (i == NL) blk_valid_in = 1'b0;
      exp_v = exp_q.pop_front();
      total++;
      if (lane_valid_out !== 1'b1 || obs !== exp_v) begin
        bad++;
        $display("FAIL b2b_beat%0d: got v=%0b rec=%h want v=1 rec=%h", i, lane_valid_out, obs, exp_v);
      end
      total++;
      if (blk_ready_out !== ((i % NL) == NL - 1)) begin
        bad++;
        $display("FAIL b2b_ready%0d: got %0b want %0b", i, blk_ready_out, ((i % NL) == NL - 1));
      end
      @(posedge clk); #1;
    end
    total++;
    if (lane_valid_out !== 1'b0) begin
      bad++;
      $display("FAIL b2b_end: got v=%0b want 0", lane_valid_out);
    end
  endtask

  task automatic test_backpressure();
    int e;
    int c;
    for (int i = 0; i < NL; i++) begin la[i] = 8'(8'h30 + i); lb[i] = 8'(8'hC0 + i); end
    lane_ready_in = 1'b0;
    send_block();
    e = 0;
    c = 0;
    while (e < NL && c < 200) begin
      exp_v = exp_q[0];
      total++;
      if (lane_valid_out !== 1'b1 || obs !== exp_v) begin
        bad++;
        $display("FAIL bp_cycle%0d: got v=%0b rec=%h want v=1 rec=%h", c, lane_valid_out, obs, exp_v);
      end
      lane_ready_in = ((c % 4) == 0) || ((c % 4) == 3);
      #1;
      total++;
      if (blk_ready_out !== ((e == NL - 1) && lane_ready_in)) begin
        bad++;
        $display("FAIL bp_ready%0d: got %0b want %0b", c, blk_ready_out, ((e == NL - 1) && lane_ready_in));
      end
      if (lane_ready_in) begin
        void'(exp_q.pop_front());
        e++;
      end
      @(posedge clk); #1;
      c++;
    end
    total++;
    if (e != NL || lane_valid_out !== 1'b0) begin
      bad++;
      $display("FAIL bp_done: got lanes=%0d v=%0b want lanes=%0d v=0", e, lane_valid_out, NL);
    end
    lane_ready_in = 1'b1;
  endtask

  task automatic test_input_change();
    for (int i = 0; i < NL; i++) begin la[i] = 8'(i * 3 + 1); lb[i] = 8'(8'h80 ^ i); end
    lane_ready_in = 1'b1;
    send_block();
    blk_a_in = '1;
    blk_b_in = '0;
    for (int i = 0; i < NL; i++) begin
      exp_v = exp_q.pop_front();
      total++;
      if (lane_valid_out !== 1'b1 || obs !== exp_v) begin
        bad++;
        $display("FAIL inchg_lane%0d: got v=%0b rec=%h want v=1 rec=%h", i, lane_valid_out, obs, exp_v);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < NL; i++) begin la[i] = 8'(8'h60 + i); lb[i] = 8'(8'h20 + i); end
    lane_ready_in = 1'b1;
    send_block();
    for (int i = 0; i < 5; i++) begin
      exp_v = exp_q.pop_front();
      total++;
      if (obs !== exp_v) begin
        bad++;
        $display("FAIL mid_pre%0d: got rec=%h want %h", i, obs, exp_v);
      end
      @(posedge clk); #1;
    end
    rst = 1'b1;
    blk_valid_in = 1'b1;
    @(posedge clk); #1;
    exp_q.delete();
    total++;
    if (obs !== '0 || lane_valid_out !== 1'b0 || blk_ready_out !== 1'b0 || dbg_state_out !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: got rec=%h v=%0b rdy=%0b st=%0b want all 0", obs, lane_valid_out, blk_ready_out, dbg_state_out);
    end
    blk_valid_in = 1'b0;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      total++;
      if (lane_valid_out !== 1'b0 || blk_ready_out !== 1'b1) begin
        bad++;
        $display("FAIL mid_quiet%0d: got v=%0b rdy=%0b want v=0 rdy=1", c, lane_valid_out, blk_ready_out);
      end
    end
    for (int i = 0; i < NL; i++) begin la[i] = 8'(8'hA0 + i); lb[i] = 8'(8'h0F - i); end
    send_block();
    for (int i = 0; i < NL; i++) begin
      exp_v = exp_q.pop_front();
      total++;
      if (lane_valid_out !== 1'b1 || obs !== exp_v) begin
        bad++;
        $display("FAIL mid_fresh%0d: got v=%0b rec=%h want v=1 rec=%h", i, lane_valid_out, obs, exp_v);
      end
      @(posedge clk); #1;
    end
    total++;
    if (lane_valid_out !== 1'b0) begin
      bad++;
      $display("FAIL mid_end: got v=%0b want 0", lane_valid_out);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_input_change();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adder_operand_serializer.md
# adder_operand_serializer

Upstream feeder for the 8-bit adder datapath. Accepts a pair of wide operand blocks (NUM_LANES lanes of DATA_W bits each) over a valid/ready handshake and presents them one lane pair per beat, LSB lane first, on the adder's operand inputs with its own valid/ready handshake. It lets the narrow adder process full-width blocks without the producer having to drive bytes itself.

## Interface
Parameters:
- DATA_W, 8, width of one lane; matches adder operand width.
- NUM_LANES, 16, lanes per block; legal range 2..256.
- IDX_W, $clog2(NUM_LANES), width of the lane index output.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- blk_valid_in  input  1  an operand block pair is offered.
- blk_ready_out  output  1  block accepted on a cycle where blk_valid_in && blk_ready_out.
- blk_a_in  input  DATA_W*NUM_LANES  operand A block; lane i = bits [i*DATA_W +: DATA_W].
- blk_b_in  input  DATA_W*NUM_LANES  operand B block; same lane layout.
- adder_a_out  output  DATA_W  current lane of A, to adder a input.
- adder_b_out  output  DATA_W  current lane of B, to adder b input.
- lane_valid_out  output  1  adder_a_out/adder_b_out hold a valid lane.
- lane_ready_in  input  1  consumer takes the lane on lane_valid_out && lane_ready_in.
- lane_idx_out  output  IDX_W  index of the current lane, 0..NUM_LANES-1.
- lane_last_out  output  1  high with the final lane (index NUM_LANES-1) of a block.

## Operation
- States: IDLE, SEND.
- IDLE: blk_ready_out = 1, lane_valid_out = 0. On block handshake: load A and B into internal shift registers, lane counter := 0, go to SEND.
- SEND: lane_valid_out = 1; adder_a_out/adder_b_out = lane 0 of the shift registers, i.e. lane number lane_idx_out of the accepted block.
- Lane handshake with counter < NUM_LANES-1: shift both registers down one lane, counter += 1, stay in SEND.
- Lane handshake with counter = NUM_LANES-1 (lane_last_out = 1): block done. If blk_valid_in is also high the same cycle, load the new block, counter := 0, stay in SEND. Otherwise go to IDLE.
- blk_ready_out = (state == IDLE) || (state == SEND && lane_last_out && lane_ready_in). Combinational, and 0 while rst is high.
- lane_last_out = (state == SEND) && (counter == NUM_LANES-1).
- No handshake (lane_ready_in = 0): all lane outputs, counter and state hold unchanged.
- blk_a_in/blk_b_in are sampled only on the block handshake cycle. Later changes have no effect on the block in flight.
- No arithmetic is done here. Lanes pass through bit-exact, with no carry between lanes.

## Timing
- Reset: state IDLE, counter 0, shift registers 0, adder_a_out = 0, adder_b_out = 0, lane_valid_out = 0, lane_idx_out = 0, lane_last_out = 0. blk_ready_out = 1 from the first cycle after rst deasserts.
- Block accepted at edge k: lane 0 is valid in the cycle after edge k.
- With lane_ready_in held high, lane i is presented in cycle k+1+i and the last lane in cycle k+NUM_LANES.
- Back-to-back blocks have zero bubble: the next block's lane 0 follows the previous last lane directly.
- Throughput: one lane per cycle; one block per NUM_LANES cycles.
- All outputs except blk_ready_out are registered.
- Reset mid-block: the in-flight block is discarded, all outputs return to reset values on the next edge, and no partial lanes are emitted afterwards.
- Reset asserted together with blk_valid_in: the block is not accepted.

## Test plan
- Reset then idle: rst high for 2 cycles, then low -> all outputs 0, blk_ready_out = 1, lane_valid_out stays 0 for 10 idle cycles.
- Single block, no stall: A lane i = i, B lane i = 8'hF0+i (NUM_LANES = 16), lane_ready_in = 1 -> cycles k+1..k+16 show a = 0..15, b = F0..FF, idx = 0..15, lane_last_out only at idx 15, then lane_valid_out = 0.
- Back-to-back: second block (A = all 8'hAA, B = all 8'h55) held valid during the first block -> accepted on the first block's last-lane cycle; its lane 0 appears the next cycle; 32 consecutive valid beats with no gap.
- Backpressure: lane_ready_in toggles 1,0,0,1 repeatedly -> outputs frozen during 0 cycles, no lane skipped or duplicated, all 16 lanes delivered in order, blk_ready_out = 0 throughout SEND except at the last-lane handshake.
- Input change after accept: alter blk_a_in to 8'hFF per lane right after the handshake -> emitted lanes still match the captured values.
- Reset mid-block: assert rst at lane 5 -> next cycle all outputs at reset values; a fresh block sent afterwards starts at idx 0 with correct data.
